note_tone_player: RTL and testbench

- Output end of the note interface driven by the piano controller.
- Consumes the 4-bit note code and 2-bit octave produced in the auto and learn modes.
- Drives the board buzzer with a square wave at the matching pitch.
- Retunes and stops only on half-period boundaries, so the speaker pin never glitches.
- Reports the sounding note and a one-cycle note-start pulse, for learn-mode scoring and LEDs.

---
 rtl/piano_pkg.sv | 47 ++++
 rtl/note_period_lut.sv | 63 ++++++
 rtl/note_tone_player.sv | 132 +++++++++++++
 tb/tb_note_tone_player.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piano_pkg
//  Description : Shared note/octave codes, middle-octave pitch table and the
//                half-period helper used by the tone player.
//  Revision    : 1.0 - initial release
// ============================================================================
package piano_pkg;

    // Note codes on the note interface; anything outside C..B is a rest
    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_C    = 4'd1;
    localparam logic [3:0] NOTE_D    = 4'd2;
    localparam logic [3:0] NOTE_E    = 4'd3;
    localparam logic [3:0] NOTE_F    = 4'd4;
    localparam logic [3:0] NOTE_G    = 4'd5;
    localparam logic [3:0] NOTE_A    = 4'd6;
    localparam logic [3:0] NOTE_B    = 4'd7;

    // Octave codes; code 3 plays the same pitch as OCT_HIGH
    localparam logic [1:0] OCT_LOW   = 2'd0;
    localparam logic [1:0] OCT_MID   = 2'd1;
    localparam logic [1:0] OCT_HIGH  = 2'd2;

    // Middle-octave frequencies in hundredths of a hertz, index 0 = C
    function automatic logic [63:0] f_centi_hz(input int idx);
        case (idx)
            0:       return 64'd26163;
            1:       return 64'd29366;
            2:       return 64'd32963;
            3:       return 64'd34923;
            4:       return 64'd39200;
            5:       return 64'd44000;
            6:       return 64'd49388;
            default: return 64'd1;
        endcase
    endfunction

    // Middle-octave half-period in clock cycles: clk_hz / (2 * f)
    // with f held in centi-hertz, hence the factor of 50
    function automatic logic [63:0] half_period_base(input logic [63:0] clk_hz,
                                                     input int          idx);
        return (clk_hz * 64'd50) / f_centi_hz(idx);
    endfunction

endpackage : piano_pkg
`default_nettype wire

// File: rtl/note_period_lut.sv
`default_nettype none
// ============================================================================
//  Module      : note_period_lut
//  Description : Combinational (note, octave) -> half-period lookup. All table
//                entries are elaboration-time constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_period_lut
    import piano_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned CNT_W  = 20
) (
    input  logic [3:0]       note_code,
    input  logic [1:0]       octave,
    output logic [CNT_W-1:0] half_period
);

    // Entry 7 is a zero pad so a 3-bit index never leaves the array
    logic [CNT_W-1:0] w_h_low  [8];
    logic [CNT_W-1:0] w_h_mid  [8];
    logic [CNT_W-1:0] w_h_high [8];
    logic [2:0]       w_idx;

    assign w_idx = 3'(note_code - NOTE_C);

    assign w_h_low[7]  = '0;
    assign w_h_mid[7]  = '0;
    assign w_h_high[7] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_note
            localparam logic [63:0] c_base = half_period_base(64'(CLK_HZ), gi);
            localparam logic [63:0] c_low  = c_base << 1;
            localparam logic [63:0] c_high = c_base >> 1;

            assign w_h_low[gi]  = c_low[CNT_W-1:0];
            assign w_h_mid[gi]  = c_base[CNT_W-1:0];
            assign w_h_high[gi] = c_high[CNT_W-1:0];

            // A zero half-period would never reach a boundary: refuse to build
            if ((c_low[CNT_W-1:0] == '0) || (c_base[CNT_W-1:0] == '0) ||
                (c_high[CNT_W-1:0] == '0)) begin : g_cfg_error
                $error("note_period_lut: CLK_HZ/CNT_W give a zero half-period");
            end
        end
    endgenerate

    // Select the octave-scaled entry; rests map to zero
    always_comb begin
        half_period = '0;
        if ((note_code >= NOTE_C) && (note_code <= NOTE_B)) begin
            case (octave)
                OCT_LOW: half_period = w_h_low[w_idx];
                OCT_MID: half_period = w_h_mid[w_idx];
                default: half_period = w_h_high[w_idx];
            endcase
        end
    end

endmodule : note_period_lut
`default_nettype wire

// File: rtl/note_tone_player.sv
`default_nettype none
// ============================================================================
//  Module      : note_tone_player
//  Description : Square-wave buzzer driver. Starts on the first valid note,
//                and only retunes or stops on half-period boundaries so the
//                speaker pin never shows a truncated phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_tone_player
    import piano_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned CNT_W  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] note_code,
    input  logic [1:0] octave,
    output logic       speaker,
    output logic       playing,
    output logic       note_start,
    output logic [3:0] active_note
);

    localparam logic [0:0]       c_ST_IDLE = 1'b0;
    localparam logic [0:0]       c_ST_TONE = 1'b1;
    localparam logic [CNT_W-1:0] c_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half;
    logic [1:0]       r_oct;
    logic [3:0]       r_note;
    logic             r_speaker;
    logic             r_note_start;

    logic [CNT_W-1:0] w_lut_h;
    logic             w_valid;
    logic             w_boundary;
    logic             w_retune;

    note_period_lut #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (CNT_W)
    ) u_lut (
        .note_code   (note_code),
        .octave      (octave),
        .half_period (w_lut_h)
    );

    assign w_valid    = enable && (note_code >= NOTE_C) && (note_code <= NOTE_B);
    assign w_boundary = (r_cnt == (r_half - c_ONE));
    // Octave is compared as a raw code, so 2 -> 3 counts as a new pair
    assign w_retune   = (note_code != r_note) || (octave != r_oct);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: start on a valid request, stop on a rest seen at a boundary
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_valid) w_state_next = c_ST_TONE;
            c_ST_TONE: if (w_boundary && !w_valid) w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // Outputs: playing follows the state, the rest come straight from registers
    always_comb begin
        playing     = (r_state == c_ST_TONE);
        speaker     = r_speaker;
        note_start  = r_note_start;
        active_note = r_note;
    end

    // Half-period counter, latched pitch and speaker level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_half       <= '0;
            r_oct        <= OCT_LOW;
            r_note       <= NOTE_REST;
            r_speaker    <= 1'b0;
            r_note_start <= 1'b0;
        end else begin
            r_note_start <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_valid) begin
                        r_speaker    <= 1'b1;
                        r_note_start <= 1'b1;
                        r_note       <= note_code;
                        r_oct        <= octave;
                        r_half       <= w_lut_h;
                        r_cnt        <= '0;
                    end
                end
                c_ST_TONE: begin
                    if (w_boundary) begin
                        r_cnt <= '0;
                        if (!w_valid) begin
                            r_speaker <= 1'b0;
                            r_note    <= NOTE_REST;
                        end else begin
                            r_speaker <= ~r_speaker;
                            if (w_retune) begin
                                r_half       <= w_lut_h;
                                r_note       <= note_code;
                                r_oct        <= octave;
                                r_note_start <= 1'b1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule : note_tone_player
`default_nettype wire

// File: tb/tb_note_tone_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_note_tone_player
//  Description : Self-checking bench for note_tone_player at CLK_HZ = 1 MHz.
//                Directed scenarios plus a randomized run against a
//                cycle-level reference of the buzzer behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_note_tone_player;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned CNT_W  = 20;
    localparam int          LIMIT  = 10000;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       enable    = 1'b0;
    logic [3:0] note_code = 4'd0;
    logic [1:0] octave    = 2'd0;
    logic       speaker;
    logic       playing;
    logic       note_start;
    logic [3:0] active_note;

    int checks = 0;
    int passed = 0;

    note_tone_player #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .note_code   (note_code),
        .octave      (octave),
        .speaker     (speaker),
        .playing     (playing),
        .note_start  (note_start),
        .active_note (active_note)
    );

    always #5 clk = ~clk;

    // Expected half-period from the pitch table and octave rule
    function automatic int hp(input int n, input int o);
        int f;
        int base;
        case (n)
            1: f = 26163;
            2: f = 29366;
            3: f = 32963;
            4: f = 34923;
            5: f = 39200;
            6: f = 44000;
            7: f = 49388;
            default: f = 0;
        endcase
        if (f == 0) return 0;
        base = (50 * CLK_HZ) / f;
        if (o == 0) return base * 2;
        if (o == 1) return base;
        return base / 2;
    endfunction

    function automatic bit req_valid(input logic en, input logic [3:0] n);
        return en && (n >= 4'd1) && (n <= 4'd7);
    endfunction

    // Reference: tracks the sounding pitch and cycles left in the current level
    logic       m_spk   = 1'b0;
    logic       m_play  = 1'b0;
    logic       m_start = 1'b0;
    logic [3:0] m_note  = 4'd0;
    logic [1:0] m_oct   = 2'd0;
    int         m_left  = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_spk   <= 1'b0;
            m_play  <= 1'b0;
            m_start <= 1'b0;
            m_note  <= 4'd0;
            m_oct   <= 2'd0;
            m_left  <= 0;
        end else begin
            m_start <= 1'b0;
            if (!m_play) begin
                if (req_valid(enable, note_code)) begin
                    m_play  <= 1'b1;
                    m_spk   <= 1'b1;
                    m_start <= 1'b1;
                    m_note  <= note_code;
                    m_oct   <= octave;
                    m_left  <= hp(int'(note_code), int'(octave));
                end
            end else if (m_left > 1) begin
                m_left <= m_left - 1;
            end else if (!req_valid(enable, note_code)) begin
                m_play <= 1'b0;
                m_spk  <= 1'b0;
                m_note <= 4'd0;
            end else begin
                m_spk  <= ~m_spk;
                m_left <= hp(int'(note_code), int'(octave));
                if ((note_code != m_note) || (octave != m_oct)) begin
                    m_start <= 1'b1;
                    m_note  <= note_code;
                    m_oct   <= octave;
                end
            end
        end
    end

    // Reset pulse that leaves inputs at rest and returns at a falling edge
    task automatic go_idle();
        reset     = 1'b0;
        enable    = 1'b0;
        note_code = 4'd0;
        octave    = 2'd0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Counts cycles until speaker changes level, and note_start pulses seen
    task automatic measure_level(output int n, output int pulses);
        logic prev;
        prev   = speaker;
        n      = 0;
        pulses = 0;
        do begin
            @(negedge clk);
            n++;
            if (note_start) pulses++;
        end while ((speaker == prev) && (n < LIMIT));
    endtask

    task automatic test_reset();
        int bad;
        #1;
        checks++;
        if ({speaker, playing, note_start, active_note} !== 7'd0) begin
            $display("FAIL reset_initial: outputs=%b required 0", {speaker, playing, note_start, active_note});
        end else passed++;
        go_idle();
        enable = 1'b1; note_code = 4'd1; octave = 2'd1;
        repeat (300) @(negedge clk);
        checks++;
        if (playing !== 1'b1 || speaker !== 1'b1) begin
            $display("FAIL reset_pre_tone: playing=%b speaker=%b required 1 1", playing, speaker);
        end else passed++;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({speaker, playing, note_start, active_note} !== 7'd0) begin
            $display("FAIL reset_mid_tone: outputs=%b required 0", {speaker, playing, note_start, active_note});
        end else passed++;
        @(negedge clk);
        note_code = 4'd0;
        reset     = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if ({speaker, playing, note_start, active_note} !== 7'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL reset_silent_after: active cycles=%0d required 0", bad);
        end else passed++;
    endtask

    task automatic test_start_c();
        int n1, n2, p1, p2;
        go_idle();
        enable = 1'b1; note_code = 4'd1; octave = 2'd1;
        @(negedge clk);
        checks++;
        if ({speaker, playing, note_start, active_note} !== {3'b111, 4'd1}) begin
            $display("FAIL start_c_first_edge: outputs=%b required %b", {speaker, playing, note_start, active_note}, {3'b111, 4'd1});
        end else passed++;
        @(negedge clk);
        checks++;
        if (note_start !== 1'b0) begin
            $display("FAIL start_c_pulse_width: note_start=%b required 0", note_start);
        end else passed++;
        measure_level(n1, p1);
        n1 = n1 + 1;
        measure_level(n2, p2);
        checks++;
        if (n1 != hp(1, 1)) begin
            $display("FAIL start_c_high: cycles=%0d required %0d", n1, hp(1, 1));
        end else passed++;
        checks++;
        if (n1 + n2 != 2 * hp(1, 1) || (p1 + p2) != 0) begin
            $display("FAIL start_c_period: period=%0d pulses=%0d required %0d 0", n1 + n2, p1 + p2, 2 * hp(1, 1));
        end else passed++;
    endtask

    task automatic test_octaves();
        int n, p;
        int exp_n [3];
        int exp_p [3];
        logic [1:0] next_oct [3];
        exp_n = '{hp(6, 0), hp(6, 2), hp(6, 3)};
        exp_p = '{1, 1, 0};
        next_oct = '{2'd2, 2'd3, 2'd3};
        go_idle();
        enable = 1'b1; note_code = 4'd6; octave = 2'd0;
        @(negedge clk);
        checks++;
        if (note_start !== 1'b1) begin
            $display("FAIL oct_start_pulse: note_start=%b required 1", note_start);
        end else passed++;
        for (int i = 0; i < 3; i++) begin
            octave = next_oct[i];
            measure_level(n, p);
            if (i == 0) n = n + 0;
            checks++;
            if (n != exp_n[i] || p != exp_p[i]) begin
                $display("FAIL oct_level_%0d: cycles=%0d pulses=%0d required %0d %0d", i, n, p, exp_n[i], exp_p[i]);
            end else passed++;
        end
    endtask

    task automatic test_glitch_ignored();
        int n, p, n2, p2;
        logic prev;
        go_idle();
        enable = 1'b1; note_code = 4'd6; octave = 2'd1;
        @(negedge clk);
        prev = speaker;
        n = 0;
        p = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1)   note_code = 4'd3;
            if (n == 500) note_code = 4'd6;
            if (note_start) p++;
        end while ((speaker == prev) && (n < LIMIT));
        checks++;
        if (n != hp(6, 1) || p != 0 || active_note !== 4'd6) begin
            $display("FAIL glitch_no_retune: cycles=%0d pulses=%0d note=%0d required %0d 0 6", n, p, active_note, hp(6, 1));
        end else passed++;
        measure_level(n2, p2);
        checks++;
        if (n2 != hp(6, 1) || p2 != 0) begin
            $display("FAIL glitch_next_level: cycles=%0d pulses=%0d required %0d 0", n2, p2, hp(6, 1));
        end else passed++;
    endtask

    task automatic test_enable_drop();
        int n, bad;
        logic prev;
        go_idle();
        enable = 1'b1; note_code = 4'd1; octave = 2'd1;
        @(negedge clk);
        prev = speaker;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 99) enable = 1'b0;
        end while ((speaker == prev) && (n < LIMIT));
        checks++;
        if (n != hp(1, 1) || {speaker, playing, active_note} !== 6'd0) begin
            $display("FAIL enable_drop_stop: cycles=%0d outputs=%b required %0d 0", n, {speaker, playing, active_note}, hp(1, 1));
        end else passed++;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if ({speaker, playing, note_start} !== 3'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL enable_drop_idle: active cycles=%0d required 0", bad);
        end else passed++;
    endtask

    task automatic test_invalid_codes();
        logic [3:0] codes [4];
        int bad;
        codes = '{4'd9, 4'd0, 4'd8, 4'd15};
        for (int i = 0; i < 4; i++) begin
            go_idle();
            enable = 1'b1; note_code = codes[i]; octave = 2'($urandom_range(0, 3));
            bad = 0;
            repeat (500) begin
                @(negedge clk);
                if (speaker || note_start || playing) bad++;
            end
            checks++;
            if (bad != 0) begin
                $display("FAIL invalid_code_%0d: active cycles=%0d required 0", codes[i], bad);
            end else passed++;
        end
        go_idle();
        enable = 1'b0; note_code = 4'd1; octave = 2'd1;
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (speaker || note_start || playing) bad++;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL invalid_disabled: active cycles=%0d required 0", bad);
        end else passed++;
    endtask

    task automatic test_random();
        int shown;
        shown = 0;
        go_idle();
        for (int cyc = 0; cyc < 12000; cyc++) begin
            @(negedge clk);
            checks++;
            if ({speaker, playing, note_start, active_note} !== {m_spk, m_play, m_start, m_note}) begin
                if (shown < 10) begin
                    $display("FAIL random_cycle_%0d: dut=%b model=%b", cyc,
                             {speaker, playing, note_start, active_note}, {m_spk, m_play, m_start, m_note});
                end
                shown++;
            end else passed++;
            if ($urandom_range(0, 249) == 0) begin
                enable    = ($urandom_range(0, 5) != 0);
                note_code = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                        : 4'($urandom_range(1, 7));
                octave    = 2'($urandom_range(0, 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_c();
        test_octaves();
        test_glitch_ignored();
        test_enable_drop();
        test_invalid_codes();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_note_tone_player
`default_nettype wire
